// File: rtl/nn_pkg.sv
// Shared types and saturating arithmetic helpers for the neuron MAC lanes.
package nn_pkg;

  typedef enum logic [1:0] {
    ACT_IDENT = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_LEAKY = 2'd2,
    ACT_RSVD  = 2'd3
  } act_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_BIAS,
    ST_ACT,
    ST_OUT
  } state_t;

  // Clamp a wide signed value into the range of a w-bit signed word.
  // Works on 64-bit carriers so callers of any width up to 62 bits can share it.
  function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] x,
                                                    input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = ~hi;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // Add two sign-extended operands and clamp the sum to w bits.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w);
    return sat_narrow(a + b, w);
  endfunction

endpackage

// File: rtl/neuron_mac_lanes_weight_bank.sv
// One lane's weight store: 1W1R RAM with a registered read port, contents not reset.
module neuron_weight_bank #(
  parameter int DEPTH = 196,
  parameter int DW    = 16,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write on load, read every cycle so the word for the accepted beat lands one cycle later.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/neuron_mac_lanes.sv
// Multi-lane fully-connected neuron: LANES MACs per beat, saturating accumulate,
// bias add and runtime-selectable activation, with a valid/ready result port.
module neuron_mac_lanes
  import nn_pkg::*;
#(
  parameter int LAYER_NO         = 0,
  parameter int NEURON_NO        = 0,
  parameter int NUM_WEIGHT       = 784,
  parameter int LANES            = 4,
  parameter int DATA_WIDTH       = 16,
  parameter int WEIGHT_INT_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [31:0]                 config_layer_num,
  input  logic [31:0]                 config_neuron_num,
  input  logic                        weight_valid,
  input  logic [DATA_WIDTH-1:0]       weight_value,
  input  logic                        bias_valid,
  input  logic [DATA_WIDTH-1:0]       bias_value,
  input  logic [1:0]                  act_mode,
  input  logic [LANES*DATA_WIDTH-1:0] input_data,
  input  logic                        input_valid,
  output logic                        input_ready,
  output logic [DATA_WIDTH-1:0]       output_data,
  output logic                        output_valid,
  input  logic                        output_ready
);

  localparam int DW     = DATA_WIDTH;
  localparam int FRAC   = DATA_WIDTH - WEIGHT_INT_WIDTH;
  localparam int BEATS  = (NUM_WEIGHT + LANES - 1) / LANES;
  localparam int AW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW     = $clog2(BEATS + 1);
  localparam int PW     = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;
  localparam int LB     = $clog2(LANES);
  localparam int ACC_W  = 2 * DATA_WIDTH;
  localparam int SW     = ACC_W + LB;
  localparam int STAGES = 2;

  state_t                          state;
  logic [CW-1:0]                   beat_cnt;
  logic [PW-1:0]                   load_ptr;
  logic signed [ACC_W-1:0]         acc;
  logic signed [ACC_W-1:0]         bias_q;

  logic                            fire;
  logic                            ld_sel;
  logic                            w_we;
  logic [PW-1:0]                   lane_of;
  logic [AW-1:0]                   w_addr;
  logic [AW-1:0]                   r_addr;
  logic [LANES-1:0]                bank_we;
  logic [LANES-1:0]                lane_ok;

  logic [LANES-1:0][DW-1:0]        x_vec;
  logic [LANES-1:0][DW-1:0]        x_s0;
  logic [LANES-1:0]                msk_s0;
  logic [LANES-1:0][DW-1:0]        w_rd;
  logic [LANES-1:0][ACC_W-1:0]     mul;
  logic [LANES-1:0][ACC_W-1:0]     prod_s1;
  logic signed [SW-1:0]            sum_c;
  logic signed [SW-1:0]            sum_s2;
  logic [STAGES:0]                 vld_pipe;

  logic signed [DW-1:0]            nx;
  logic signed [DW-1:0]            act_res;

  assign fire    = input_valid && input_ready;
  assign ld_sel  = (config_layer_num == 32'(LAYER_NO)) &&
                   (config_neuron_num == 32'(NEURON_NO)) && (state == ST_IDLE);
  assign w_we    = ld_sel && weight_valid;
  assign lane_of = load_ptr & PW'(LANES - 1);
  assign w_addr  = AW'(load_ptr >> LB);
  assign r_addr  = AW'(beat_cnt);
  assign x_vec   = input_data;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign bank_we[i] = w_we && (lane_of == PW'(i));
    // Lanes past the last weight on the final beat are padding and contribute nothing.
    assign lane_ok[i] = (int'(beat_cnt) * LANES + i) < NUM_WEIGHT;
    // Both operands signed, so they sign-extend to the 2*DW product width.
    assign mul[i]     = $signed(w_rd[i]) * $signed(x_s0[i]);

    neuron_weight_bank #(
      .DEPTH (BEATS),
      .DW    (DW),
      .AW    (AW)
    ) u_bank (
      .clk   (clk),
      .we    (bank_we[i]),
      .waddr (w_addr),
      .wdata (weight_value),
      .raddr (r_addr),
      .rdata (w_rd[i])
    );
  end

  // Lane-sum tree, widened so the sum of LANES full-scale products cannot wrap.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < LANES; i++) sum_c = sum_c + SW'($signed(prod_s1[i]));
  end

  // Narrow the accumulator back to DW and apply the selected activation.
  always_comb begin
    nx = DW'(sat_narrow(64'(acc) >>> FRAC, DW));
    case (act_mode_t'(act_mode))
      ACT_RELU:  act_res = nx[DW-1] ? '0 : nx;
      ACT_LEAKY: act_res = nx[DW-1] ? (nx >>> 3) : nx;
      default:   act_res = nx;
    endcase
  end

  // Beat valid shift register tracking data through read, multiply and sum stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[STAGES-1:0], fire};
  end

  // Datapath stages: capture beat with its padding mask, multiply, then lane-sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_s0    <= '0;
      msk_s0  <= '0;
      prod_s1 <= '0;
      sum_s2  <= '0;
    end else begin
      if (fire) begin
        x_s0   <= x_vec;
        msk_s0 <= lane_ok;
      end
      if (vld_pipe[0]) begin
        for (int i = 0; i < LANES; i++) prod_s1[i] <= msk_s0[i] ? mul[i] : '0;
      end
      if (vld_pipe[1]) sum_s2 <= sum_c;
    end
  end

  // Weight pointer and bias register; loads only land while idle and addressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_ptr <= '0;
      bias_q   <= '0;
    end else begin
      if (w_we) load_ptr <= (load_ptr == PW'(NUM_WEIGHT - 1)) ? '0 : load_ptr + 1'b1;
      if (ld_sel && bias_valid) bias_q <= ACC_W'(64'($signed(bias_value)) <<< FRAC);
    end
  end

  // Control FSM owning the accumulator, beat count and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      input_ready  <= 1'b0;
      output_valid <= 1'b0;
      output_data  <= '0;
      acc          <= '0;
      beat_cnt     <= '0;
    end else begin
      if (fire)            beat_cnt <= beat_cnt + 1'b1;
      if (vld_pipe[STAGES]) acc     <= ACC_W'(sat_add(64'(acc), 64'(sum_s2), ACC_W));
      case (state)
        ST_IDLE: begin
          input_ready <= 1'b1;
          if (fire) begin
            state       <= ST_ACCUM;
            input_ready <= (BEATS > 1);
          end
        end
        ST_ACCUM: begin
          if (fire && beat_cnt == CW'(BEATS - 1)) input_ready <= 1'b0;
          // Leave only once every beat is in and the pipeline has drained.
          if (beat_cnt == CW'(BEATS) && vld_pipe == '0) state <= ST_BIAS;
        end
        ST_BIAS: begin
          acc   <= ACC_W'(sat_add(64'(acc), 64'(bias_q), ACC_W));
          state <= ST_ACT;
        end
        ST_ACT: begin
          output_data  <= act_res;
          output_valid <= 1'b1;
          state        <= ST_OUT;
        end
        ST_OUT: begin
          if (output_ready) begin
            output_valid <= 1'b0;
            acc          <= '0;
            beat_cnt     <= '0;
            input_ready  <= 1'b1;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
